// File: rtl/ram_port_b_arbiter.sv
// Port B arbiter for the shared I/D RAM: r0 = CPU load/store, r1 = loader/debug, per-cycle round robin.
// Define MEM_ARB_LOCK_EN to enable locked ownership (OWN0/OWN1 states, lock_cnt timeout, lock_err).
module ram_port_b_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic              r0_we,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r0_lock,
    input  logic              r1_lock,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr2,
    output logic              ram_w_en2,
    output logic [DATA_W-1:0] ram_in2,
    input  logic [DATA_W-1:0] ram_data2,
    output logic              lock_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       rr_last_q, rr_last_d;
    logic [1:0] rvalid_q, rvalid_d;
    logic       gnt0, gnt1;
    logic       force_rr, force_rr_val;

    // rr_last_q names the requester granted most recently; a tie goes to the other one.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            ST_OWN0: gnt0 = r0_req;
            ST_OWN1: gnt1 = r1_req;
            default: begin
                if (r0_req && r1_req) begin
                    gnt0 = rr_last_q;
                    gnt1 = !rr_last_q;
                end else begin
                    gnt0 = r0_req;
                    gnt1 = r1_req;
                end
            end
        endcase
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // With no grant the port idles as a harmless read at r0's address.
    always_comb begin
        ram_addr2 = gnt1 ? r1_addr  : r0_addr;
        ram_in2   = gnt1 ? r1_wdata : r0_wdata;
        ram_w_en2 = (gnt0 && r0_we) || (gnt1 && r1_we);
    end

    always_comb begin
        rvalid_d  = {gnt1 && !r1_we, gnt0 && !r0_we};
        rr_last_d = rr_last_q;
        if (gnt1) begin
            rr_last_d = 1'b1;
        end else if (gnt0) begin
            rr_last_d = 1'b0;
        end
        if (force_rr) begin
            rr_last_d = force_rr_val;
        end
    end

`ifdef MEM_ARB_LOCK_EN
    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_err_q, lock_err_d;

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        lock_err_d   = 1'b0;
        force_rr     = 1'b0;
        force_rr_val = 1'b0;
        case (state_q)
            ST_OWN0: begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
                if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                    state_d      = ST_IDLE;
                    lock_cnt_d   = '0;
                    lock_err_d   = 1'b1;
                    force_rr     = 1'b1;
                    force_rr_val = 1'b0;
                end else if ((gnt0 && !r0_lock) || (!r0_req && !r0_lock)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN1: begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
                if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                    state_d      = ST_IDLE;
                    lock_cnt_d   = '0;
                    lock_err_d   = 1'b1;
                    force_rr     = 1'b1;
                    force_rr_val = 1'b1;
                end else if ((gnt1 && !r1_lock) || (!r1_req && !r1_lock)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
                if (gnt0 && r0_lock) begin
                    state_d = ST_OWN0;
                end else if (gnt1 && r1_lock) begin
                    state_d = ST_OWN1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            lock_err_q <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign lock_err = lock_err_q;
`else
    // Lock inputs and LOCK_MAX have no effect in the pure round-robin build.
    logic unused_lock;
    assign unused_lock = r0_lock ^ r1_lock ^ (LOCK_MAX > 0);

    always_comb begin
        state_d      = ST_IDLE;
        force_rr     = 1'b0;
        force_rr_val = 1'b0;
    end

    assign lock_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_last_q <= 1'b1;
            rvalid_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;
    assign r0_rvalid = rvalid_q[0];
    assign r1_rvalid = rvalid_q[1];
    assign rdata     = ram_data2;

endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// Self-checking bench for ram_port_b_arbiter: directed scenarios plus a randomized run against a
// requester-level reference model; lock scenarios are built only when MEM_ARB_LOCK_EN is defined.
module tb_ram_port_b_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int LM = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_req, r1_req, r0_we, r1_we, r0_lock, r1_lock;
    logic [AW-1:0] r0_addr, r1_addr, ram_addr2;
    logic [DW-1:0] r0_wdata, r1_wdata, rdata, ram_in2, ram_data2;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, ram_w_en2, lock_err;

    logic          bd_en = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    bit   [DW-1:0] mem [0:(1<<AW)-1];
    bit            mem_wr [0:(1<<AW)-1];

    bit   [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            ref_wr [0:(1<<AW)-1];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ram_port_b_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_lock(r0_lock), .r1_lock(r1_lock), .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid), .rdata(rdata),
        .ram_addr2(ram_addr2), .ram_w_en2(ram_w_en2), .ram_in2(ram_in2),
        .ram_data2(ram_data2), .lock_err(lock_err)
    );

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Synchronous-read RAM behind port B, with a backdoor for preloading.
    always @(posedge clk) begin
        if (bd_en) begin
            mem[bd_addr]    <= bd_data;
            mem_wr[bd_addr] <= 1'b1;
        end else if (ram_w_en2) begin
            mem[ram_addr2]    <= ram_in2;
            mem_wr[ram_addr2] <= 1'b1;
        end
        ram_data2 <= mem_wr[ram_addr2] ? mem[ram_addr2] : dflt(ram_addr2);
    end

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : dflt(a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0; r0_lock = 0; r1_lock = 0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        r0_req = 1; r0_we = 1; r1_req = 1; r1_we = 1;
        @(negedge clk);
        total++; if (r0_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt0: got %b want 0", r0_gnt); end
        total++; if (r1_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt1: got %b want 0", r1_gnt); end
        total++; if (ram_w_en2 !== 1'b0) begin bad++; $display("FAIL rst_wen: got %b want 0", ram_w_en2); end
        total++; if ({r1_rvalid, r0_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %b want 00", {r1_rvalid, r0_rvalid}); end
        total++; if (lock_err !== 1'b0) begin bad++; $display("FAIL rst_lock_err: got %b want 0", lock_err); end
        apply_reset();
    endtask

    task automatic test_single_read();
        bd_en = 1; bd_addr = 11'h010; bd_data = 32'h1234_5678;
        tick();
        bd_en = 0;
        r0_req = 1; r0_we = 0; r0_addr = 11'h010;
        @(negedge clk);
        total++; if (r0_gnt !== 1'b1) begin bad++; $display("FAIL sr_gnt0: got %b want 1", r0_gnt); end
        total++; if (r1_gnt !== 1'b0) begin bad++; $display("FAIL sr_gnt1: got %b want 0", r1_gnt); end
        total++; if (ram_addr2 !== 11'h010 || ram_w_en2 !== 1'b0) begin bad++; $display("FAIL sr_port: got addr %h wen %b want 010/0", ram_addr2, ram_w_en2); end
        tick();
        idle_inputs();
        @(negedge clk);
        total++; if (r0_rvalid !== 1'b1) begin bad++; $display("FAIL sr_rvalid0: got %b want 1", r0_rvalid); end
        total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL sr_rdata: got %h want 12345678", rdata); end
        total++; if (r1_rvalid !== 1'b0) begin bad++; $display("FAIL sr_rvalid1: got %b want 0", r1_rvalid); end
        tick();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        r0_req = 1; r0_we = 0; r0_addr = 11'h100;
        r1_req = 1; r1_we = 0; r1_addr = 11'h101;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                r0_req = 0; r1_req = 0;
            end
            @(negedge clk);
            if (i < 6) begin
                total++; if (r0_gnt !== (i % 2 == 0)) begin bad++; $display("FAIL rr_gnt0[%0d]: got %b want %b", i, r0_gnt, (i % 2 == 0)); end
                total++; if (r1_gnt !== (i % 2 == 1)) begin bad++; $display("FAIL rr_gnt1[%0d]: got %b want %b", i, r1_gnt, (i % 2 == 1)); end
            end
            if (i > 0) begin
                total++; if (r0_rvalid !== ((i - 1) % 2 == 0) || r1_rvalid !== ((i - 1) % 2 == 1)) begin
                    bad++; $display("FAIL rr_rvalid[%0d]: got %b%b", i, r1_rvalid, r0_rvalid);
                end
                total++; if (rdata !== (((i - 1) % 2 == 0) ? 32'hA500_0100 : 32'hA500_0101)) begin
                    bad++; $display("FAIL rr_rdata[%0d]: got %h", i, rdata);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_write_then_read();
        r1_req = 1; r1_we = 1; r1_addr = 11'h7FF; r1_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (r1_gnt !== 1'b1 || ram_w_en2 !== 1'b1) begin bad++; $display("FAIL wr_gnt: got gnt %b wen %b want 1/1", r1_gnt, ram_w_en2); end
        total++; if (ram_addr2 !== 11'h7FF || ram_in2 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_port: got %h/%h want 7ff/deadbeef", ram_addr2, ram_in2); end
        tick();
        idle_inputs();
        r0_req = 1; r0_we = 0; r0_addr = 11'h7FF;
        @(negedge clk);
        total++; if (r0_gnt !== 1'b1 || r1_rvalid !== 1'b0) begin bad++; $display("FAIL wr_rd_gnt: got gnt0 %b rv1 %b want 1/0", r0_gnt, r1_rvalid); end
        tick();
        idle_inputs();
        @(negedge clk);
        total++; if (r0_rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_rd_data: got rv %b data %h want 1/deadbeef", r0_rvalid, rdata); end
        tick();
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        r0_req = 1; r0_we = 0; r0_lock = 1; r0_addr = 11'h020;
        r1_req = 1; r1_we = 0; r1_addr = 11'h030;
        @(negedge clk);
        total++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin bad++; $display("FAIL lk_enter: got %b%b want gnt0", r1_gnt, r0_gnt); end
        tick();
        r0_req = 0;
        @(negedge clk);
        total++; if (r1_gnt !== 1'b0) begin bad++; $display("FAIL lk_hold: got r1_gnt %b want 0", r1_gnt); end
        tick();
        r0_req = 1; r0_we = 1; r0_lock = 0; r0_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        total++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin bad++; $display("FAIL lk_release: got %b%b want gnt0", r1_gnt, r0_gnt); end
        tick();
        r0_req = 0; r0_we = 0;
        @(negedge clk);
        total++; if (r1_gnt !== 1'b1) begin bad++; $display("FAIL lk_after: got r1_gnt %b want 1", r1_gnt); end
        tick();
        idle_inputs();
    endtask

    task automatic test_lock_timeout();
        apply_reset();
        r0_req = 1; r0_we = 0; r0_lock = 1; r0_addr = 11'h040;
        tick();
        r0_req = 0; r1_req = 1; r1_addr = 11'h041;
        for (int k = 1; k <= LM; k++) begin
            @(negedge clk);
            total++; if (r1_gnt !== 1'b0 || lock_err !== 1'b0) begin bad++; $display("FAIL to_hold[%0d]: got gnt1 %b err %b want 0/0", k, r1_gnt, lock_err); end
            tick();
        end
        @(negedge clk);
        total++; if (lock_err !== 1'b1 || r1_gnt !== 1'b1) begin bad++; $display("FAIL to_fire: got err %b gnt1 %b want 1/1", lock_err, r1_gnt); end
        tick();
        idle_inputs();
        @(negedge clk);
        total++; if (lock_err !== 1'b0) begin bad++; $display("FAIL to_pulse: got err %b want 0", lock_err); end
        tick();
    endtask
`else
    task automatic test_lock_ignored();
        apply_reset();
        r0_req = 1; r0_we = 0; r0_lock = 1; r0_addr = 11'h102;
        @(negedge clk);
        total++; if (r0_gnt !== 1'b1) begin bad++; $display("FAIL li_first: got gnt0 %b want 1", r0_gnt); end
        tick();
        r1_req = 1; r1_lock = 1; r1_addr = 11'h103;
        @(negedge clk);
        total++; if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0) begin bad++; $display("FAIL li_tie: got %b%b want gnt1", r1_gnt, r0_gnt); end
        tick();
        r1_req = 0;
        @(negedge clk);
        total++; if (r0_gnt !== 1'b1 || lock_err !== 1'b0) begin bad++; $display("FAIL li_back: got gnt0 %b err %b want 1/0", r0_gnt, lock_err); end
        tick();
        idle_inputs();
    endtask
`endif

    task automatic test_reset_mid_read();
        r1_req = 1; r1_we = 0; r1_addr = 11'h104;
        @(negedge clk);
        total++; if (r1_gnt !== 1'b1) begin bad++; $display("FAIL mr_gnt1: got %b want 1", r1_gnt); end
        tick();
        rst_n = 0;
        idle_inputs();
        r0_req = 1; r0_we = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (r1_rvalid !== 1'b0 || ram_w_en2 !== 1'b0 || r0_gnt !== 1'b0) begin
                bad++; $display("FAIL mr_in_reset[%0d]: got rv1 %b wen %b gnt0 %b want 0/0/0", k, r1_rvalid, ram_w_en2, r0_gnt);
            end
            tick();
        end
        idle_inputs();
        rst_n = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (r1_rvalid !== 1'b0 || r0_rvalid !== 1'b0) begin bad++; $display("FAIL mr_after[%0d]: got %b%b want 00", k, r1_rvalid, r0_rvalid); end
            tick();
        end
    endtask

    // Requesters hold a request until granted; the model picks the winner from the fairness rule.
    task automatic test_random();
        bit p0 = 0, p1 = 0, last = 1, ev0 = 0, ev1 = 0, e0, e1;
        logic [DW-1:0] edata = '0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(1, 0) == 1) begin
                p0 = 1; r0_we = 1'($urandom_range(1, 0));
                r0_addr = AW'(11'h200 + $urandom_range(15, 0)); r0_wdata = $urandom;
`ifdef MEM_ARB_LOCK_EN
                r0_lock = 0;
`else
                r0_lock = 1'($urandom_range(1, 0));
`endif
            end
            if (!p1 && $urandom_range(1, 0) == 1) begin
                p1 = 1; r1_we = 1'($urandom_range(1, 0));
                r1_addr = AW'(11'h200 + $urandom_range(15, 0)); r1_wdata = $urandom;
`ifdef MEM_ARB_LOCK_EN
                r1_lock = 0;
`else
                r1_lock = 1'($urandom_range(1, 0));
`endif
            end
            r0_req = p0; r1_req = p1;
            @(negedge clk);
            if (p0 && p1) begin
                e0 = (last == 1); e1 = (last == 0);
            end else begin
                e0 = p0; e1 = p1;
            end
            total++; if (r0_gnt !== e0 || r1_gnt !== e1) begin bad++; $display("FAIL rnd_gnt[%0d]: got %b%b want %b%b", c, r1_gnt, r0_gnt, e1, e0); end
            total++; if (ram_w_en2 !== ((e0 && r0_we) || (e1 && r1_we))) begin bad++; $display("FAIL rnd_wen[%0d]: got %b", c, ram_w_en2); end
            total++; if (ram_addr2 !== (e1 ? r1_addr : r0_addr)) begin bad++; $display("FAIL rnd_addr[%0d]: got %h", c, ram_addr2); end
            if ((e0 && r0_we) || (e1 && r1_we)) begin
                total++; if (ram_in2 !== (e1 ? r1_wdata : r0_wdata)) begin bad++; $display("FAIL rnd_wdata[%0d]: got %h", c, ram_in2); end
            end
            total++; if (r0_rvalid !== ev0 || r1_rvalid !== ev1) begin bad++; $display("FAIL rnd_rvalid[%0d]: got %b%b want %b%b", c, r1_rvalid, r0_rvalid, ev1, ev0); end
            if (ev0 || ev1) begin
                total++; if (rdata !== edata) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rdata, edata); end
            end
            ev0 = e0 && !r0_we;
            ev1 = e1 && !r1_we;
            if (e0) begin
                if (r0_we) begin ref_mem[r0_addr] = r0_wdata; ref_wr[r0_addr] = 1; end
                else edata = ref_read(r0_addr);
                p0 = 0; last = 0;
            end
            if (e1) begin
                if (r1_we) begin ref_mem[r1_addr] = r1_wdata; ref_wr[r1_addr] = 1; end
                else edata = ref_read(r1_addr);
                p1 = 0; last = 1;
            end
            tick();
            if (!p0) r0_req = 0;
            if (!p1) r1_req = 0;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write_then_read();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
        test_lock_timeout();
`else
        test_lock_ignored();
`endif
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_port_b_arbiter.md
# ram_port_b_arbiter

Shares port B of the dual-port instruction/data RAM between two requesters: requester 0 is the CPU load/store path, requester 1 is the program loader/debug port. Port A stays dedicated to instruction fetch. The block provides per-cycle round-robin arbitration and an optional locked-ownership mode for atomic read-modify-write sequences. It tracks the RAM's 1-cycle synchronous read latency so each requester gets its own read-valid strobe.

## Interface

- `ADDR_W`, default 11: RAM word-address width.
- `DATA_W`, default 32: RAM data width.
- `LOCK_MAX`, default 16: maximum cycles a lock may be held before forced release.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `r0_req`, `r1_req` input, 1: access request; held high until granted.
- `r0_we`, `r1_we` input, 1: 1 = write, 0 = read; valid while req is high.
- `r0_addr`, `r1_addr` input, ADDR_W: word address.
- `r0_wdata`, `r1_wdata` input, DATA_W: write data.
- `r0_lock`, `r1_lock` input, 1: request exclusive ownership starting with this access.
- `r0_gnt`, `r1_gnt` output, 1: access accepted this cycle (combinational).
- `r0_rvalid`, `r1_rvalid` output, 1: read data valid this cycle (registered).
- `rdata` output, DATA_W: shared read data, a direct pass-through of `ram_data2`.
- `ram_addr2` output, ADDR_W: address to RAM port B.
- `ram_w_en2` output, 1: write enable to RAM port B.
- `ram_in2` output, DATA_W: write data to RAM port B.
- `ram_data2` input, DATA_W: RAM port B read data, one cycle after address.
- `lock_err` output, 1: one-cycle pulse when a lock is force-released on timeout.

## Operation

- **State machine states:**
  - `IDLE`: no owner; round-robin arbitration between requesters.
  - `OWN0` / `OWN1`: the named requester owns the port; only it can be granted.
- **Arbitration in `IDLE`:**
  - Grant goes to the single requester with req high.
  - If both are requesting, grant goes to the requester not granted last. The `rr_last` pointer records this and resets to 1, so r0 wins the first tie.
  - At most one gnt is high in any cycle.
- **Port drive:**
  - With a grant, `ram_addr2`, `ram_in2` and `ram_w_en2` take the granted requester's addr, wdata and we.
  - With no grant, `ram_w_en2` = 0 and `ram_addr2`/`ram_in2` hold the r0 values (read with no side effect).
- **Read return:** a granted read sets `rvalid_owner`. In the next cycle, that requester's rvalid = 1 and `rdata` = `ram_data2`. Writes produce no rvalid.
- **Entering ownership:** a granted access with its lock high moves `IDLE` to `OWNx` and clears `lock_cnt`.
- **In `OWNx`:**
  - Only x can be granted; the other requester's gnt is forced to 0.
  - Every cycle increments `lock_cnt`.
- **Leaving ownership:**
  - A granted access with lock low returns to `IDLE`. That access completes normally.
  - x having both req and lock low also returns to `IDLE`.
- **Lock timeout:** when `lock_cnt` reaches LOCK_MAX-1 while still in `OWNx`:
  - the state forces to `IDLE` and `lock_err` pulses for one cycle;
  - `rr_last` is set to x, so the other requester wins the next tie.
- **Boundary conditions:**
  - Back-to-back reads by alternating requesters pipeline with no bubble. Each rvalid goes to the correct owner.
  - A write and a read to the same address in consecutive cycles return the new data, since port B reads after the write edge.
  - A lock request from the non-owner while in `OWNx` is ignored until `IDLE`.

## Timing

- Grant latency is 0 cycles: gnt is combinational from req, state and `rr_last`.
- Read latency is 1 cycle from the gnt cycle to rvalid.
- Throughput is one access per cycle.
- Reset (async assert, sync-safe deassert):
  - state = `IDLE`, `rr_last` = 1, `lock_cnt` = 0;
  - `r0_rvalid`, `r1_rvalid`, `lock_err` = 0;
  - `ram_w_en2` and both gnt are forced to 0 while `rst_n` is low.
- Reset mid-read: the pending rvalid is discarded and no rvalid is issued after release.
- `lock_err` is a registered pulse, high in the cycle after the timeout edge.

## Configuration

- `MEM_ARB_LOCK_EN` defined: lock inputs, the `OWN0`/`OWN1` states, `lock_cnt` and `lock_err` behave as above.
- `MEM_ARB_LOCK_EN` not defined:
  - `r0_lock`/`r1_lock` are ignored and the FSM remains in `IDLE` (pure round-robin);
  - `lock_err` is tied to 0 and no `lock_cnt` logic is synthesized.

## Test plan

- r0 reads addr 0x010 (RAM holds 0x12345678), r1 idle -> `r0_gnt` in the same cycle, `r0_rvalid` = 1 with `rdata` = 0x12345678 the next cycle, `r1_rvalid` stays 0.
- Both requesters hold req continuously for 6 cycles after reset -> grants r0, r1, r0, r1, r0, r1, with exactly one gnt per cycle.
- r1 writes 0xDEADBEEF to 0x7FF, then r0 reads 0x7FF the next cycle -> `r0_rvalid` with `rdata` = 0xDEADBEEF.
- With `MEM_ARB_LOCK_EN`, r0 does a locked read of 0x020 then an unlocked write to 0x020 two cycles later, while r1 requests throughout -> `r1_gnt` = 0 until the cycle after r0's unlocked write, then `r1_gnt` = 1.
- With LOCK_MAX = 8, r0 asserts lock and stops requesting with lock held -> `lock_err` pulses once, about 8 cycles after entry, and r1 is granted the following cycle.
- Assert `rst_n` = 0 in the cycle after a granted r1 read -> `r1_rvalid` = 0 during reset and after release, and `ram_w_en2` = 0 throughout reset.
